// File: rtl/dm_responder_if.sv
// Load/store port between the core's data access path and dm_responder.
// The core raises req with a stable request; the responder answers with a one-cycle ready strobe.
interface dm_responder_if;
    // req is sampled only while the responder is idle (busy=0); the request is captured on that edge.
    // ready is a single-cycle strobe; rdata and err are meaningful only while ready=1.
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] pc;
    logic        ready;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata, byte_en, pc,
        input  ready, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata, byte_en, pc,
        output ready, rdata, busy, err
    );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: programmable wait states, byte-lane store merge,
// range/lane error reporting and a MARS-style store log.
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dm_responder_if.slave    bus,
    output logic [1:0]       dbg_state_o
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic [3:0]  be_q;
    logic        ready_q, err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, enter_resp;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata, acc_pc;
    logic [3:0]  acc_be;
    logic [AW-1:0] word_idx;
    logic [31:0] old_word, merged, rdata_c;
    logic        in_range, be_legal, err_c, commit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, before anything is latched.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_be    = bus.byte_en;
            acc_pc    = bus.pc;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_pc    = pc_q;
        end
    end

    always_comb begin
        word_idx = acc_addr[AW+1:2];
        old_word = mem_q[word_idx];
        in_range = ({1'b0, acc_addr} < ADDR_LIMIT);
        unique case (acc_be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
            default:                            be_legal = 1'b0;
        endcase
        merged = old_word;
        for (int l = 0; l < 4; l++) begin
            if (acc_be[l]) merged[8*l +: 8] = acc_wdata[8*l +: 8];
        end
        err_c   = !in_range || (acc_we && !be_legal);
        commit  = acc_we && !err_c;
        rdata_c = err_c ? 32'h0 : (acc_we ? merged : old_word);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            pc_q    <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                be_q    <= bus.byte_en;
                pc_q    <= bus.pc;
            end
            ready_q <= enter_resp;
            err_q   <= enter_resp && err_c;
            rdata_q <= enter_resp ? rdata_c : 32'h0;
            if (enter_resp && commit) mem_q[word_idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && commit)
            $display("%d@%h: *%h <= %h", $time, acc_pc, {acc_addr[31:2], 2'b00}, merged);
    end
`endif

    assign bus.ready   = ready_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dm_responder.sv
// Randomized scoreboard bench for dm_responder against a word-array memory model.
module tb_dm_responder;
    localparam int DEPTH_WORDS = 1024;
    localparam int WAIT_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    dm_responder_if bus();

    dm_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    // {check_rdata, err, rdata}
    logic [33:0] exp_q[$];
    logic [31:0] model_mem [DEPTH_WORDS];
    logic [3:0]  legal_be [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH_WORDS; i++) model_mem[i] = 32'h0;
    endfunction

    function automatic logic [33:0] model_access(input logic we, input logic [31:0] addr,
                                                 input logic [31:0] wdata, input logic [3:0] be);
        logic        legal;
        logic [31:0] word;
        int          idx;
        legal = 1'b0;
        foreach (legal_be[k]) if (legal_be[k] == be) legal = 1'b1;
        if (64'(addr) >= 64'(4 * DEPTH_WORDS)) return {1'b1, 1'b1, 32'h0};
        if (we && !legal) return {1'b0, 1'b1, 32'h0};
        idx  = int'(addr / 4);
        word = model_mem[idx];
        if (we) begin
            for (int l = 0; l < 4; l++) if (be[l]) word[8*l +: 8] = wdata[8*l +: 8];
            model_mem[idx] = word;
        end
        return {1'b1, 1'b0, word};
    endfunction

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc);
        bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.byte_en = be; bus.pc = pc;
    endtask

    // One request; inputs are scrambled after acceptance, then busy length up to ready is measured.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int   n_busy;
        logic seen;
        @(negedge clk);
        drive(we, addr, wdata, be, $urandom);
        bus.req = 1'b1;
        exp_q.push_back(model_access(we, addr, wdata, be));
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        drive(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom);
        n_busy = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) n_busy++;
            if (bus.ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(n_busy), 32'(WAIT_CYCLES + 1));
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int n_ready;
        n_ready = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.ready) n_ready++;
        end
        check(name, 32'(n_ready), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (!reset) begin
            if (bus.ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL resp_unexpected: got ready with err=%0b rdata=%h, expected no response",
                             bus.err, bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.err !== e[32] || (e[33] && bus.rdata !== e[31:0])) begin
                        n_bad++;
                        $display("FAIL resp: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                                 bus.err, bus.rdata, e[32], e[31:0]);
                    end
                end
            end else begin
                check("err_idle", 32'(bus.err), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc, p, idle_gap;
        int          times [3];
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        int          sel;

        reset   = 1'b1;
        bus.req = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        issue(1'b0, 32'h0, 32'h0, 4'b1111);
        issue(1'b1, 32'h10, 32'h12345678, 4'b1111);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);
        issue(1'b1, 32'h11, 32'h0000AB00, 4'b0010);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0110);
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111);
        issue(1'b0, 32'h1000, 32'h0, 4'b1111);
        issue(1'b0, 32'h10, 32'h0, 4'b0000);

        // req held high for three back-to-back loads
        @(negedge clk);
        drive(1'b0, 32'h10, 32'h0, 4'b1111, 32'h400);
        bus.req = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(model_access(1'b0, 32'h10, 32'h0, 4'b1111));
        cyc = 0; p = 0; idle_gap = 0;
        times = '{0, 0, 0};
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (p >= 1 && !bus.busy) idle_gap++;
            if (bus.ready) begin
                times[p] = cyc;
                p++;
                if (p == 3) break;
            end
        end
        bus.req = 1'b0;
        check("hold_pulses", 32'(p), 32'd3);
        check("hold_gap01", 32'(times[1] - times[0]), 32'(WAIT_CYCLES + 2));
        check("hold_gap12", 32'(times[2] - times[1]), 32'(WAIT_CYCLES + 2));
        check("hold_idle", 32'(idle_gap), 32'd2);

        // reset during the WAIT state of a store
        @(negedge clk);
        drive(1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, 32'h500);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("abort_busy", 32'(bus.busy), 32'd0);
        expect_quiet("abort_no_ready", 6);
        issue(1'b0, 32'h20, 32'h0, 4'b1111);
        issue(1'b0, 32'h10, 32'h0, 4'b1111);

        // reset and req together: reset wins
        @(negedge clk);
        drive(1'b0, 32'h10, 32'h0, 4'b1111, 32'h600);
        reset   = 1'b1;
        bus.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 1'b0;
        model_clear();
        check("rst_req_busy", 32'(bus.busy), 32'd0);
        expect_quiet("rst_req_no_ready", 6);

        for (int t = 0; t < 60; t++) begin
            we  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'h1000 + $urandom_range(0, 255);
            else if (sel == 1) addr = $urandom;
            else               addr = $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) be = 4'($urandom);
            else                           be = legal_be[$urandom_range(0, 6)];
            issue(we, addr, $urandom, be);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
